dns_zreduce: RTL and testbench

DNS_ZREDUCE -- requirements
Module: dns_zreduce

---
 rtl/dns_pkg.sv | 18 +
 rtl/dns_add_stage.sv | 43 ++++
 rtl/dns_zreduce.sv | 96 +++++++++
 tb/tb_dns_zreduce.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dns_pkg.sv
// Shared constants and width helper for the z-layer reduction block.
package dns_pkg;

  localparam int unsigned DNS_DW = 8;
  localparam int unsigned DNS_P  = 4;
  localparam int unsigned DNS_N  = 4;

  // Ceiling log2, used for tree depth and index widths.
  function automatic int unsigned dns_log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dns_add_stage.sv
// One adder-tree level: sums adjacent pairs, widens by one bit, registers the
// result and its valid bit when the pipeline advances.
module dns_add_stage #(
  parameter int unsigned IW = 8,
  parameter int unsigned NI = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         adv,
  input  logic                         in_valid,
  input  logic [NI*IW-1:0]             in_data,
  output logic                         out_valid,
  output logic [(NI/2)*(IW+1)-1:0]     out_data
);

  localparam int unsigned NO = NI / 2;
  localparam int unsigned OW = IW + 1;

  logic [NO*OW-1:0] sum_c;

  // Pairwise adders, zero-extended so no carry is lost.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NO; k++) begin
      sum_c[k*OW +: OW] = OW'(in_data[(2*k)*IW +: IW]) + OW'(in_data[(2*k+1)*IW +: IW]);
    end
  end

  // Stage register: clear drops the valid bit only; data may stay stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= in_valid;
      out_data  <= sum_c;
    end
  end

endmodule

// File: rtl/dns_zreduce.sv
// Sums P z-layer products per (i,j) position through a pipelined adder tree
// and tags each result with its row-major matrix index.
module dns_zreduce
  import dns_pkg::*;
#(
  parameter int unsigned P  = DNS_P,
  parameter int unsigned DW = DNS_DW,
  parameter int unsigned N  = DNS_N
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [P*DW-1:0]             in_prod,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DW+dns_log2(P)-1:0]   out_sum,
  output logic [dns_log2(N)-1:0]      out_row,
  output logic [dns_log2(N)-1:0]      out_col,
  output logic                        done
);

  localparam int unsigned S  = dns_log2(P);
  localparam int unsigned LN = dns_log2(N);

  logic adv;
  logic ohs;
  logic last;

  // Whole pipeline stalls only when the output holds an unaccepted result.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;
  assign ohs      = out_valid && out_ready;
  assign last     = (out_row == LN'(N - 1)) && (out_col == LN'(N - 1));

  // Adder tree: level s reduces P>>s operands of width DW+s.
  for (genvar s = 0; s < S; s++) begin : g_stage
    localparam int unsigned IW = DW + s;
    localparam int unsigned NI = P >> s;

    logic [NI*IW-1:0]         din;
    logic                     vin;
    logic [(NI/2)*(IW+1)-1:0] dout;
    logic                     vout;

    if (s == 0) begin : g_first
      assign din = in_prod;
      assign vin = in_valid;
    end else begin : g_next
      assign din = g_stage[s-1].dout;
      assign vin = g_stage[s-1].vout;
    end

    dns_add_stage #(
      .IW(IW),
      .NI(NI)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .adv      (adv),
      .in_valid (vin),
      .in_data  (din),
      .out_valid(vout),
      .out_data (dout)
    );
  end

  assign out_sum   = g_stage[S-1].dout;
  assign out_valid = g_stage[S-1].vout;

  // Row-major index counters and end-of-matrix pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_row <= '0;
      out_col <= '0;
      done    <= 1'b0;
    end else if (clr) begin
      out_row <= '0;
      out_col <= '0;
      done    <= 1'b0;
    end else begin
      done <= ohs && last;
      if (ohs) begin
        if (out_col == LN'(N - 1)) begin
          out_col <= '0;
          out_row <= last ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dns_zreduce.sv
// Directed bench for dns_zreduce (P=4, DW=8, N=4): table of hand-computed
// sums streamed through a scoreboard, plus stall, clear and reset sequences.
module tb_dns_zreduce;

  localparam int N = 4;

  typedef struct {
    logic [31:0] prod;
    logic [9:0]  sum;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_prod = '0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic [9:0]  out_sum;
  logic [1:0]  out_row;
  logic [1:0]  out_col;
  logic        done;

  always #5 clk = ~clk;

  dns_zreduce #(.P(4), .DW(8), .N(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_prod  (in_prod),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_row  (out_row),
    .out_col  (out_col),
    .done     (done)
  );

  int         n_vec = 0;
  int         n_bad = 0;
  logic [9:0] q[$];
  bit         mon_en = 1'b0;
  int         mrow = 0;
  int         mcol = 0;
  bit         exp_done = 1'b0;
  bit         stalled_prev = 1'b0;
  logic [9:0] held = '0;
  logic [9:0] e;
  int         done_cnt = 0;
  vec_t       tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample until accepted; queue its expected sum on acceptance.
  task automatic send(input vec_t v);
    in_valid = 1'b1;
    in_prod  = v.prod;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready && !clr) begin
        q.push_back(v.sum);
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    n_vec++;
    n_bad++;
    $display("FAIL send_timeout: got in_ready=%0d expected 1 within 50 cycles", in_ready);
  endtask

  // Scoreboard: order, indices, done timing, stall stability, in_ready.
  always @(negedge clk) begin
    if (!mon_en) begin
      q.delete();
      mrow = 0;
      mcol = 0;
      exp_done = 1'b0;
      stalled_prev = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      chk("done", 32'(done), 32'(exp_done));
      if (done) done_cnt++;
      if (stalled_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_sum", 32'(out_sum), 32'(held));
      end
      exp_done = 1'b0;
      if (clr) begin
        q.delete();
        mrow = 0;
        mcol = 0;
      end else if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("sum", 32'(out_sum), 32'(e));
          chk("row", 32'(out_row), 32'(mrow));
          chk("col", 32'(out_col), 32'(mcol));
        end
        exp_done = (mrow == N - 1) && (mcol == N - 1);
        if (mcol == N - 1) begin
          mcol = 0;
          mrow = (mrow == N - 1) ? 0 : mrow + 1;
        end else begin
          mcol++;
        end
      end
      stalled_prev = out_valid && !out_ready && !clr;
      held = out_sum;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{prod: 32'h04030201, sum: 10'd10};
    tbl[1]  = '{prod: 32'hFFFFFFFF, sum: 10'd1020};
    tbl[2]  = '{prod: 32'h00000000, sum: 10'd0};
    tbl[3]  = '{prod: 32'h80808080, sum: 10'd512};
    tbl[4]  = '{prod: 32'h01020304, sum: 10'd10};
    tbl[5]  = '{prod: 32'hFF000000, sum: 10'd255};
    tbl[6]  = '{prod: 32'h000000FF, sum: 10'd255};
    tbl[7]  = '{prod: 32'h10203040, sum: 10'd160};
    tbl[8]  = '{prod: 32'hFFFF0000, sum: 10'd510};
    tbl[9]  = '{prod: 32'h0000FFFF, sum: 10'd510};
    tbl[10] = '{prod: 32'h7F7F7F7F, sum: 10'd508};
    tbl[11] = '{prod: 32'h01010101, sum: 10'd4};
    tbl[12] = '{prod: 32'hAA55AA55, sum: 10'd510};
    tbl[13] = '{prod: 32'hC8000064, sum: 10'd300};
    tbl[14] = '{prod: 32'h0A141E28, sum: 10'd100};
    tbl[15] = '{prod: 32'hFE01FE01, sum: 10'd510};

    // Reset values, before any clock edge.
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_row", 32'(out_row), 32'd0);
    chk("rst_col", 32'(out_col), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) tick();
    rst = 1'b1;
    mon_en = 1'b1;

    // Basic sum with two-cycle latency.
    send(tbl[0]);
    chk("lat_early", 32'(out_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_sum", 32'(out_sum), 32'd10);
    chk("lat_row", 32'(out_row), 32'd0);
    chk("lat_col", 32'(out_col), 32'd0);
    repeat (3) tick();

    // Idle clear resets the index counters.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_idle_row", 32'(out_row), 32'd0);
    chk("clr_idle_col", 32'(out_col), 32'd0);

    // Full matrix back-to-back, then a 17th result.
    done_cnt = 0;
    for (int i = 0; i < 16; i++) send(tbl[i]);
    send(tbl[3]);
    repeat (5) tick();
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("drain_matrix", 32'(q.size()), 32'd0);

    // Backpressure: output stalled for four cycles.
    out_ready = 1'b0;
    fork
      begin
        send(tbl[7]);
        send(tbl[12]);
        send(tbl[13]);
      end
      begin
        repeat (4) tick();
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_sum", 32'(out_sum), 32'd160);
        repeat (2) tick();
        out_ready = 1'b1;
      end
    join
    repeat (5) tick();
    chk("drain_bp", 32'(q.size()), 32'd0);

    // Clear with two samples in flight after five delivered.
    for (int i = 8; i < 15; i++) send(tbl[i]);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_row", 32'(out_row), 32'd0);
    chk("clr_col", 32'(out_col), 32'd0);
    send(tbl[15]);
    repeat (4) tick();
    chk("drain_clr", 32'(q.size()), 32'd0);

    // Asynchronous reset between edges while a result is valid.
    send(tbl[0]);
    send(tbl[1]);
    send(tbl[2]);
    for (int n = 0; n < 10 && !out_valid; n++) tick();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_row", 32'(out_row), 32'd0);
    chk("arst_col", 32'(out_col), 32'd0);
    chk("arst_sum", 32'(out_sum), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) tick();
    rst = 1'b1;
    mon_en = 1'b1;
    send(tbl[4]);
    repeat (4) tick();
    chk("drain_rst", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
